// File: rtl/fifo_read_streamer_if.sv
// fifo_read_streamer_if: FIFO read side and output stream handshake bundle.
interface fifo_read_streamer_if #(parameter int DSIZE = 8);
    logic             rempty;
    logic [DSIZE-1:0] rdata;
    logic             rinc;
    logic             m_valid;
    logic [DSIZE-1:0] m_data;
    logic             m_last;
    logic             m_ready;
    modport master(input rempty, rdata, m_ready, output rinc, m_valid, m_data, m_last);
    modport slave(output rempty, rdata, m_ready, input rinc, m_valid, m_data, m_last);
endinterface

// File: rtl/fifo_read_streamer.sv
// fifo_read_streamer: pops a FWFT FIFO into a 2-entry buffer and streams framed beats.
module fifo_read_streamer #(
    parameter int DSIZE     = 8,
    parameter int FRAME_LEN = 16
) (
    input  logic                        rclk,
    input  logic                        rrst,
    input  logic                        abort,
    fifo_read_streamer_if.master        bus,
    output logic [15:0]                 frame_cnt
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_t;
    occ_t             occ, occ_nx;
    logic [DSIZE-1:0] head, tail;
    logic [15:0]      beat;
    logic             push, pop;
    always_comb begin
        push        = !bus.rempty && occ != TWO && !abort && !rrst;
        pop         = occ != EMPTY && bus.m_ready && !abort;
        occ_nx      = occ;
        if (abort) occ_nx = EMPTY;
        else if (push && !pop) occ_nx = occ == EMPTY ? ONE : TWO;
        else if (pop && !push) occ_nx = occ == TWO ? ONE : EMPTY;
        bus.rinc    = push;
        bus.m_valid = occ != EMPTY;
        bus.m_data  = head;
        bus.m_last  = occ != EMPTY && beat == 16'(FRAME_LEN - 1);
    end
    always_ff @(posedge rclk) occ <= rrst ? EMPTY : occ_nx;
    // head is always the oldest word; tail only fills while head is still waiting
    always_ff @(posedge rclk) begin
        if (rrst) begin
            head      <= '0;
            tail      <= '0;
            beat      <= '0;
            frame_cnt <= '0;
        end else begin
            if (push && (occ == EMPTY || (occ == ONE && pop))) head <= bus.rdata;
            else if (pop && occ == TWO) head <= tail;
            if (push && occ == ONE && !pop) tail <= bus.rdata;
            beat <= abort ? '0 : !pop ? beat : beat == 16'(FRAME_LEN - 1) ? '0 : beat + 16'd1;
            if (pop && bus.m_last) frame_cnt <= frame_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_fifo_read_streamer.sv
// tb_fifo_read_streamer: directed and random checks against a queue-based reference model.
module tb_fifo_read_streamer;
    localparam int FL = 4;
    logic        rclk = 0;
    logic        rrst = 1;
    logic        abort = 0;
    logic        stall = 0;
    logic        ready = 0;
    logic [15:0] frame_cnt;
    logic [7:0]  mem [0:4095];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic        fifo_pop = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [7:0]  exp_q [$];
    int          beat = 0;
    int          frames = 0;
    bit          mv = 0;
    int          cyc = 0;
    logic [7:0]  log_d [$];
    bit          log_l [$];
    int          log_c [$];
    logic        e_rinc;
    int          sz;
    fifo_read_streamer_if #(.DSIZE(8)) bus ();
    fifo_read_streamer #(.DSIZE(8), .FRAME_LEN(FL)) dut (
        .rclk(rclk), .rrst(rrst), .abort(abort), .bus(bus), .frame_cnt(frame_cnt)
    );
    always #5 rclk = ~rclk;
    assign bus.rempty  = stall || (rd_ptr == wr_ptr);
    assign bus.rdata   = mem[rd_ptr[11:0]];
    assign bus.m_ready = ready;
    always @(posedge rclk) if (fifo_pop) rd_ptr <= rd_ptr + 1;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge rclk);
            #1;
        end
    endtask
    task automatic push_word(input logic [7:0] b);
        mem[wr_ptr[11:0]] = b;
        wr_ptr++;
    endtask
    task automatic clear_log();
        log_d.delete();
        log_l.delete();
        log_c.delete();
    endtask
    // model: buffer = words popped but not yet transferred; frame position counts transfers
    always @(negedge rclk) begin
        sz     = exp_q.size();
        e_rinc = !bus.rempty && sz < 2 && !abort && !rrst;
        if (rrst || mv) chk("rinc", bus.rinc, e_rinc);
        if (mv) begin
            chk("m_valid", bus.m_valid, sz != 0);
            chk("m_last", bus.m_last, sz != 0 && beat == FL - 1);
            if (sz != 0) chk("m_data", bus.m_data, exp_q[0]);
            chk("frame_cnt", frame_cnt, frames);
        end
        fifo_pop = bus.rinc;
        if (rrst) begin
            exp_q.delete();
            beat   = 0;
            frames = 0;
            mv     = 1;
        end else if (abort) begin
            exp_q.delete();
            beat = 0;
        end else begin
            if (sz != 0 && ready) begin
                log_d.push_back(exp_q[0]);
                log_l.push_back(beat == FL - 1);
                log_c.push_back(cyc);
                void'(exp_q.pop_front());
                if (beat == FL - 1) begin
                    beat   = 0;
                    frames = (frames + 1) % 65536;
                end else beat++;
            end
            if (e_rinc) exp_q.push_back(bus.rdata);
        end
        cyc++;
    end
    initial begin
        int rd0, bad_d, bad_l, k;
        push_word(8'hAA);
        tick(2);
        rrst = 0;
        chk("rst_valid", bus.m_valid, 0);
        chk("rst_last", bus.m_last, 0);
        chk("rst_data", bus.m_data, 0);
        chk("rst_frame", frame_cnt, 0);
        chk("rst_nopop", rd_ptr, 0);
        ready = 1;
        tick(4);
        push_word(8'h11);
        @(negedge rclk);
        chk("lat_rinc", bus.rinc, 1);
        @(posedge rclk);
        #1;
        chk("lat_valid", bus.m_valid, 1);
        chk("lat_data", bus.m_data, 8'h11);
        tick(1);
        chk("lat_idle", bus.m_valid, 0);
        ready = 0;
        rd0   = rd_ptr;
        for (int i = 1; i <= 5; i++) push_word(8'(i));
        tick(5);
        chk("bp_valid", bus.m_valid, 1);
        chk("bp_data", bus.m_data, 8'h01);
        chk("bp_rinc", bus.rinc, 0);
        chk("bp_pops", rd_ptr - rd0, 2);
        clear_log();
        ready = 1;
        tick(7);
        chk("bp_count", log_d.size(), 5);
        if (log_d.size() >= 5) begin
            for (int i = 0; i < 5; i++) chk("bp_order", log_d[i], i + 1);
            chk("bp_rate", log_c[4] - log_c[0], 4);
        end
        rrst = 1;
        tick(1);
        rrst = 0;
        clear_log();
        for (int i = 1; i <= 9; i++) push_word(8'(i));
        tick(14);
        chk("frm_cnt", frame_cnt, 2);
        chk("frm_count", log_d.size(), 9);
        if (log_d.size() >= 9) for (int i = 0; i < 9; i++) chk("frm_last", log_l[i], i == 3 || i == 7);
        for (int i = 10; i <= 12; i++) push_word(8'(i));
        tick(5);
        if (log_d.size() >= 12) chk("frm_next_last", {log_l[8], log_l[9], log_l[10], log_l[11]}, 4'b0001);
        chk("frm_cnt3", frame_cnt, 3);
        clear_log();
        ready = 1;
        for (int i = 8'h21; i <= 8'h28; i++) push_word(8'(i));
        for (k = 0; k < 20 && log_d.size() < 2; k++) tick(1);
        chk("ab_pre", log_d.size(), 2);
        ready = 0;
        tick(2);
        chk("ab_two_valid", bus.m_valid, 1);
        chk("ab_two_rinc", bus.rinc, 0);
        rd0   = rd_ptr;
        abort = 1;
        tick(1);
        abort = 0;
        chk("ab_valid", bus.m_valid, 0);
        chk("ab_nopop", rd_ptr, rd0);
        chk("ab_frame", frame_cnt, 3);
        clear_log();
        ready = 1;
        tick(8);
        chk("ab_count", log_d.size(), 4);
        if (log_d.size() >= 4) begin
            chk("ab_first", log_d[0], 8'h25);
            chk("ab_last", {log_l[0], log_l[1], log_l[2], log_l[3]}, 4'b0001);
        end
        chk("ab_frame4", frame_cnt, 4);
        clear_log();
        for (int i = 0; i < 1000; i++) push_word(8'(i));
        for (k = 0; k < 20000 && log_d.size() < 1000; k++) begin
            stall = $urandom_range(0, 3) == 0;
            ready = $urandom_range(0, 3) != 0;
            tick(1);
        end
        stall = 0;
        ready = 1;
        tick(3);
        chk("rnd_count", log_d.size(), 1000);
        bad_d = 0;
        bad_l = 0;
        for (int i = 0; i < log_d.size(); i++) begin
            if (log_d[i] != 8'(i)) bad_d++;
            if (log_l[i] != (i % FL == FL - 1)) bad_l++;
        end
        chk("rnd_order", bad_d, 0);
        chk("rnd_last", bad_l, 0);
        chk("rnd_frame", frame_cnt, 254);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
